// File: rtl/interchange_rob_allocator.sv
// Purpose: allocates consecutive circular ROB IDs to up to `lanes` instructions per cycle, frees them on in-order retire, tracks per-unit load and idle.
// Latency: 1 cycle from accept to robEn_o/robId_o/payload; freeCount_o and unitLoad_o update on the same edge.
// Backpressure: stall_o is raised combinationally when the request needs more entries than are free; upstream holds its inputs.
module interchange_rob_allocator #(
    parameter int lanes                   = 4,
    parameter int robIndexWidth           = 7,
    parameter int instructionCounterWidth = 64,
    parameter int PidSize                 = 32,
    parameter int TidSize                 = 64,
    parameter int funcUnitCodeSize        = 3,
    parameter int idleCycles              = 16
) (
    input  logic                                                      clock_i,
    input  logic                                                      reset_i,
    input  logic [0:lanes-1]                                          enable_i,
    input  logic [0:lanes*instructionCounterWidth-1]                  majID_i,
    input  logic [0:lanes*PidSize-1]                                  pid_i,
    input  logic [0:lanes*TidSize-1]                                  tid_i,
    input  logic [0:lanes*funcUnitCodeSize-1]                         funcUnitType_i,
    output logic                                                      stall_o,
    output logic [0:lanes-1]                                          robEn_o,
    output logic [0:lanes*robIndexWidth-1]                            robId_o,
    output logic [0:lanes*instructionCounterWidth-1]                  majID_o,
    output logic [0:lanes*PidSize-1]                                  pid_o,
    output logic [0:lanes*TidSize-1]                                  tid_o,
    output logic [0:lanes*funcUnitCodeSize-1]                         funcUnitType_o,
    input  logic [0:lanes-1]                                          retireEn_i,
    input  logic [0:lanes*funcUnitCodeSize-1]                         retireFuncUnit_i,
    output logic                                                      retireErr_o,
    output logic [0:(1<<funcUnitCodeSize)*(robIndexWidth+1)-1]        unitLoad_o,
    output logic [0:(1<<funcUnitCodeSize)-1]                          unitIdle_o,
    output logic [0:robIndexWidth]                                    freeCount_o
);

    localparam int IW    = robIndexWidth;
    localparam int CW    = robIndexWidth + 1;
    localparam int FW    = funcUnitCodeSize;
    localparam int UNITS = 1 << funcUnitCodeSize;
    localparam int ICW   = $clog2(idleCycles + 1);
    localparam logic [CW-1:0]  DEPTH    = CW'(1 << robIndexWidth);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(idleCycles);

    logic [IW-1:0]  tail_q, head_q;
    logic [CW-1:0]  free_q;
    logic [CW-1:0]  load_q     [UNITS];
    logic [ICW-1:0] idle_cnt_q [UNITS];

    logic [CW-1:0]  alloc_cnt, ret_cnt, alloc_take, ret_take;
    logic [IW-1:0]  lane_id [lanes];
    logic           ret_gap, ret_contig, ret_legal, accept;
    logic [CW-1:0]  unit_alloc [UNITS];
    logic [CW-1:0]  unit_ret   [UNITS];

    // Lane IDs are tail plus the number of enabled lanes below, so disabled lanes leave no holes.
    always_comb begin
        alloc_cnt  = '0;
        ret_cnt    = '0;
        ret_gap    = 1'b0;
        ret_contig = 1'b1;
        for (int k = 0; k < lanes; k++) begin
            lane_id[k] = tail_q + alloc_cnt[IW-1:0];
            if (enable_i[k]) alloc_cnt = alloc_cnt + CW'(1);
        end
        for (int k = 0; k < lanes; k++) begin
            if (retireEn_i[k]) begin
                if (ret_gap) ret_contig = 1'b0;
                ret_cnt = ret_cnt + CW'(1);
            end else begin
                ret_gap = 1'b1;
            end
        end
    end

    // Registered free only: a same-cycle retire never unblocks allocation.
    assign stall_o    = alloc_cnt > free_q;
    assign accept     = (alloc_cnt != '0) && !stall_o;
    assign ret_legal  = ret_contig && (ret_cnt <= DEPTH - free_q);
    assign alloc_take = accept ? alloc_cnt : '0;
    assign ret_take   = ret_legal ? ret_cnt : '0;

    always_comb begin
        for (int u = 0; u < UNITS; u++) begin
            unit_alloc[u] = '0;
            unit_ret[u]   = '0;
            for (int k = 0; k < lanes; k++) begin
                if (accept && enable_i[k] && funcUnitType_i[k*FW +: FW] == FW'(u))
                    unit_alloc[u] = unit_alloc[u] + CW'(1);
                if (ret_legal && retireEn_i[k] && retireFuncUnit_i[k*FW +: FW] == FW'(u))
                    unit_ret[u] = unit_ret[u] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            tail_q         <= '0;
            head_q         <= '0;
            free_q         <= DEPTH;
            retireErr_o    <= 1'b0;
            robEn_o        <= '0;
            robId_o        <= '0;
            majID_o        <= '0;
            pid_o          <= '0;
            tid_o          <= '0;
            funcUnitType_o <= '0;
            for (int u = 0; u < UNITS; u++) begin
                load_q[u]     <= '0;
                idle_cnt_q[u] <= IDLE_MAX;
            end
        end else begin
            tail_q         <= tail_q + alloc_take[IW-1:0];
            head_q         <= head_q + ret_take[IW-1:0];
            free_q         <= free_q - alloc_take + ret_take;
            retireErr_o    <= !ret_legal;
            majID_o        <= majID_i;
            pid_o          <= pid_i;
            tid_o          <= tid_i;
            funcUnitType_o <= funcUnitType_i;
            for (int k = 0; k < lanes; k++) begin
                robEn_o[k]            <= accept && enable_i[k];
                robId_o[k*IW +: IW]   <= lane_id[k];
            end
            // Idle counting looks at the load before this edge; a new allocation forces busy at once.
            for (int u = 0; u < UNITS; u++) begin
                load_q[u] <= load_q[u] + unit_alloc[u] - unit_ret[u];
                if (unit_alloc[u] != '0 || load_q[u] != '0)
                    idle_cnt_q[u] <= '0;
                else if (idle_cnt_q[u] != IDLE_MAX)
                    idle_cnt_q[u] <= idle_cnt_q[u] + ICW'(1);
            end
        end
    end

    always_comb begin
        freeCount_o = free_q;
        unitLoad_o  = '0;
        unitIdle_o  = '0;
        for (int u = 0; u < UNITS; u++) begin
            unitLoad_o[u*CW +: CW] = load_q[u];
            unitIdle_o[u]          = (idle_cnt_q[u] == IDLE_MAX);
        end
    end

endmodule

// File: tb/tb_interchange_rob_allocator.sv
// Bench for interchange_rob_allocator: lanes=4, depth 8, idleCycles=4; per-cycle scoreboard plus directed scenario checks.
module tb_interchange_rob_allocator;

    localparam int L  = 4;
    localparam int IW = 3;
    localparam int MW = 16;
    localparam int PW = 8;
    localparam int TW = 8;
    localparam int FW = 3;
    localparam int NU = 8;
    localparam int IDLE = 4;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b0;
    logic [0:L-1]      enable_i = '0;
    logic [0:L*MW-1]   majID_i = '0;
    logic [0:L*PW-1]   pid_i = '0;
    logic [0:L*TW-1]   tid_i = '0;
    logic [0:L*FW-1]   funcUnitType_i = '0;
    logic [0:L-1]      retireEn_i = '0;
    logic [0:L*FW-1]   retireFuncUnit_i = '0;
    logic              stall_o;
    logic [0:L-1]      robEn_o;
    logic [0:L*IW-1]   robId_o;
    logic [0:L*MW-1]   majID_o;
    logic [0:L*PW-1]   pid_o;
    logic [0:L*TW-1]   tid_o;
    logic [0:L*FW-1]   funcUnitType_o;
    logic              retireErr_o;
    logic [0:NU*4-1]   unitLoad_o;
    logic [0:NU-1]     unitIdle_o;
    logic [0:3]        freeCount_o;

    interchange_rob_allocator #(
        .lanes(L), .robIndexWidth(IW), .instructionCounterWidth(MW),
        .PidSize(PW), .TidSize(TW), .funcUnitCodeSize(FW), .idleCycles(IDLE)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .majID_i(majID_i),
        .pid_i(pid_i), .tid_i(tid_i), .funcUnitType_i(funcUnitType_i), .stall_o(stall_o),
        .robEn_o(robEn_o), .robId_o(robId_o), .majID_o(majID_o), .pid_o(pid_o), .tid_o(tid_o),
        .funcUnitType_o(funcUnitType_o), .retireEn_i(retireEn_i),
        .retireFuncUnit_i(retireFuncUnit_i), .retireErr_o(retireErr_o),
        .unitLoad_o(unitLoad_o), .unitIdle_o(unitIdle_o), .freeCount_o(freeCount_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [0:3]  en;
        logic [0:11] ids;
        logic [0:63] maj;
        logic [0:15] pt;
        logic [0:11] fu;
        logic        acc;
        logic        err;
        logic [0:3]  free;
        logic [0:31] load;
        logic [0:7]  idle;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   seq = 0;

    // Reference state
    int   m_free, m_tail;
    int   m_load [NU];
    int   m_idle [NU];
    int   m_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_free = 8;
        m_tail = 0;
        m_q.delete();
        for (int u = 0; u < NU; u++) begin
            m_load[u] = 0;
            m_idle[u] = IDLE;
        end
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b1;
        enable_i = '0;
        retireEn_i = '0;
        @(posedge clock_i);
        #1;
        model_reset();
        check_eq("rst_robEn", robEn_o, 0);
        check_eq("rst_free", freeCount_o, 8);
        check_eq("rst_idle", unitIdle_o, 8'hff);
        check_eq("rst_load", unitLoad_o, 0);
        check_eq("rst_err", retireErr_o, 0);
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    task automatic step(input logic [0:3] en, input logic [0:11] fu, input logic [0:3] ren);
        int n, r, off, unit;
        logic stall_x, acc, legal;
        logic [0:3] pre;
        logic [0:11] rfu, act_ids;
        logic alloc_to [NU];
        exp_t e, got;
        rfu = '0;
        for (int k = 0; k < L; k++)
            if (k < m_q.size()) rfu[k*FW +: FW] = 3'(m_q[k]);
        @(negedge clock_i);
        enable_i = en;
        funcUnitType_i = fu;
        retireEn_i = ren;
        retireFuncUnit_i = rfu;
        for (int k = 0; k < L; k++) begin
            majID_i[k*MW +: MW] = 16'(seq * 4 + k);
            pid_i[k*PW +: PW] = 8'($urandom);
            tid_i[k*TW +: TW] = 8'($urandom);
        end
        #1;
        n = 0;
        r = 0;
        for (int k = 0; k < L; k++) begin
            n += int'(en[k]);
            r += int'(ren[k]);
        end
        stall_x = n > m_free;
        check_eq("stall_o", stall_o, stall_x);
        acc = (n > 0) && !stall_x;
        for (int k = 0; k < L; k++) pre[k] = (k < r);
        legal = (ren == pre) && (r <= 8 - m_free);

        e.acc = acc;
        e.en = acc ? en : 4'b0000;
        e.ids = '0;
        off = 0;
        for (int k = 0; k < L; k++)
            if (acc && en[k]) begin
                e.ids[k*IW +: IW] = 3'(m_tail + off);
                off++;
            end
        e.maj = majID_i;
        e.pt = {pid_i[0 +: PW], tid_i[0 +: TW]};
        e.fu = fu;
        e.err = !legal;

        for (int u = 0; u < NU; u++) alloc_to[u] = 1'b0;
        for (int k = 0; k < L; k++)
            if (acc && en[k]) alloc_to[fu[k*FW +: FW]] = 1'b1;
        for (int u = 0; u < NU; u++) begin
            if (alloc_to[u] || m_load[u] != 0) m_idle[u] = 0;
            else if (m_idle[u] < IDLE) m_idle[u]++;
        end
        if (legal)
            for (int k = 0; k < r; k++) begin
                unit = m_q.pop_front();
                m_load[unit]--;
            end
        if (acc)
            for (int k = 0; k < L; k++)
                if (en[k]) begin
                    unit = int'(fu[k*FW +: FW]);
                    m_q.push_back(unit);
                    m_load[unit]++;
                end
        m_free = m_free - (acc ? n : 0) + (legal ? r : 0);
        m_tail = (m_tail + (acc ? n : 0)) % 8;
        e.free = 4'(m_free);
        for (int u = 0; u < NU; u++) begin
            e.load[u*4 +: 4] = 4'(m_load[u]);
            e.idle[u] = (m_idle[u] == IDLE);
        end
        sb.push_back(e);

        @(posedge clock_i);
        #1;
        got = sb.pop_front();
        for (int k = 0; k < L; k++)
            act_ids[k*IW +: IW] = robEn_o[k] ? robId_o[k*IW +: IW] : 3'd0;
        check_eq("robEn_o", robEn_o, got.en);
        check_eq("robId_o", act_ids, got.ids);
        if (got.acc) begin
            check_eq("majID_o", majID_o, got.maj);
            check_eq("pid_tid_o", {pid_o[0 +: PW], tid_o[0 +: TW]}, got.pt);
            check_eq("funcUnitType_o", funcUnitType_o, got.fu);
        end
        check_eq("retireErr_o", retireErr_o, got.err);
        check_eq("freeCount_o", freeCount_o, got.free);
        check_eq("unitLoad_o", unitLoad_o, got.load);
        check_eq("unitIdle_o", unitIdle_o, got.idle);
        seq++;
    endtask

    function automatic logic [0:11] fu4(input logic [2:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    initial begin
        logic [0:3] en, ren;
        logic [0:11] fu;
        int inflight, r;

        model_reset();
        do_reset();

        // Full-width allocation from reset
        step(4'b1111, fu4(0, 1, 0, 2), 4'b0000);
        check_eq("t1_ids", robId_o, {3'd0, 3'd1, 3'd2, 3'd3});
        check_eq("t1_free", freeCount_o, 4);
        check_eq("t1_load_u0", unitLoad_o[0 +: 4], 2);
        check_eq("t1_load_u1", unitLoad_o[4 +: 4], 1);
        check_eq("t1_load_u2", unitLoad_o[8 +: 4], 1);
        check_eq("t1_idle_u012", unitIdle_o[0 +: 3], 3'b000);

        // Sparse lanes, then an oversized request
        step(4'b1010, fu4(1, 0, 1, 0), 4'b0000);
        check_eq("t2_robEn", robEn_o, 4'b1010);
        check_eq("t2_id_l0", robId_o[0 +: 3], 4);
        check_eq("t2_id_l2", robId_o[6 +: 3], 5);
        step(4'b1111, fu4(2, 2, 2, 2), 4'b0000);
        check_eq("t2_stall_robEn", robEn_o, 4'b0000);

        // Wrap-around
        step(4'b1100, fu4(3, 3, 0, 0), 4'b0000);
        step(4'b0000, fu4(0, 0, 0, 0), 4'b1111);
        step(4'b1111, fu4(0, 0, 0, 0), 4'b0000);
        check_eq("t3_ids", robId_o, {3'd0, 3'd1, 3'd2, 3'd3});
        check_eq("t3_free", freeCount_o, 0);

        // Retire does not help same-cycle allocation
        step(4'b1000, fu4(0, 0, 0, 0), 4'b1100);
        check_eq("t4_robEn", robEn_o, 4'b0000);
        check_eq("t4_free", freeCount_o, 2);
        step(4'b1000, fu4(0, 0, 0, 0), 4'b0000);
        check_eq("t4_retry_robEn", robEn_o, 4'b1000);
        check_eq("t4_retry_id", robId_o[0 +: 3], 4);

        // Illegal retires
        step(4'b0000, fu4(0, 0, 0, 0), 4'b1011);
        check_eq("t5_err_gap", retireErr_o, 1);
        check_eq("t5_free_gap", freeCount_o, 1);
        step(4'b0000, fu4(0, 0, 0, 0), 4'b0000);
        check_eq("t5_err_pulse", retireErr_o, 0);
        step(4'b0000, fu4(0, 0, 0, 0), 4'b1111);
        step(4'b0000, fu4(0, 0, 0, 0), 4'b1000);
        step(4'b0000, fu4(0, 0, 0, 0), 4'b1110);
        check_eq("t5_err_over", retireErr_o, 1);
        check_eq("t5_free_over", freeCount_o, 6);

        // Idle after drain
        step(4'b0000, fu4(0, 0, 0, 0), 4'b1100);
        check_eq("t6_load_u0", unitLoad_o[0 +: 4], 0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, fu4(0, 0, 0, 0), 4'b0000);
            check_eq("t6_idle_low", unitIdle_o[0], 0);
        end
        step(4'b0000, fu4(0, 0, 0, 0), 4'b0000);
        check_eq("t6_idle_rise", unitIdle_o[0], 1);

        // Mid-stream reset
        step(4'b1111, fu4(5, 5, 5, 5), 4'b0000);
        do_reset();
        step(4'b0100, fu4(0, 0, 0, 0), 4'b0000);
        check_eq("t7_first_id", robId_o[3 +: 3], 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            en = 4'($urandom);
            for (int k = 0; k < L; k++) fu[k*FW +: FW] = 3'($urandom);
            inflight = 8 - m_free;
            r = $urandom_range(0, (inflight < 4) ? inflight : 4);
            for (int k = 0; k < L; k++) ren[k] = (k < r);
            if ($urandom_range(0, 7) == 0) ren = 4'($urandom);
            step(en, fu, ren);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interchange_rob_allocator.md
# interchange_rob_allocator

Parametrised successor to the 4-wide interchange front end. Each cycle it accepts up to `lanes` decoded instructions, allocates consecutive global ROB IDs from a circular ROB, and registers the tagged instructions toward the ROB and backend dispatch queues. It frees entries on in-order retire. It also keeps a per-functional-unit in-flight load count and an idle flag, which the interchange uses to clock-gate or down-clock lightly loaded OoO backends.

## Interface
Parameters:
- `lanes`, 4: instructions accepted per cycle.
- `robIndexWidth`, 7: ROB depth is 2^robIndexWidth.
- `instructionCounterWidth`, 64: major ID width.
- `PidSize`, 32 / `TidSize`, 64: process and thread ID widths.
- `funcUnitCodeSize`, 3: number of units is 2^funcUnitCodeSize.
- `idleCycles`, 16: cycles of zero load before a unit is flagged idle.

Ports. Vectors are `[0:N-1]`; lane k occupies slice k*w to k*w+w-1.
- `clock_i`  in  1  clock; all state changes on posedge.
- `reset_i`  in  1  synchronous, active-high reset.
- `enable_i`  in  lanes  per-lane instruction valid.
- `majID_i`  in  lanes*instructionCounterWidth  major IDs.
- `pid_i` / `tid_i`  in  lanes*PidSize / lanes*TidSize  process and thread IDs.
- `funcUnitType_i`  in  lanes*funcUnitCodeSize  target backend.
- `stall_o`  out  1  combinational; the request this cycle cannot be accepted.
- `robEn_o`  out  lanes  registered lane valid.
- `robId_o`  out  lanes*robIndexWidth  allocated ROB IDs.
- `majID_o`, `pid_o`, `tid_o`, `funcUnitType_o`  out  same widths as inputs  registered copies of the inputs.
- `retireEn_i`  in  lanes  retire the oldest entries; must be contiguous from bit 0.
- `retireFuncUnit_i`  in  lanes*funcUnitCodeSize  unit of each retiring entry.
- `retireErr_o`  out  1  registered pulse on an illegal retire.
- `unitLoad_o`  out  2^funcUnitCodeSize*(robIndexWidth+1)  in-flight count per unit.
- `unitIdle_o`  out  2^funcUnitCodeSize  unit idle flag.
- `freeCount_o`  out  robIndexWidth+1  free ROB entries.

## Operation
- State:
  - `tail`, the next ROB ID to allocate, robIndexWidth bits.
  - `head`, the oldest in-flight ID.
  - `free`, robIndexWidth+1 bits.
  - Per-unit load counters.
  - Per-unit idle counters, saturating at idleCycles.
- Allocation:
  - n = popcount(enable_i).
  - `stall_o` = (n > free). It uses the registered `free`; a retire in the same cycle does not help allocation.
  - Accept when n>0 and !stall_o. Enabled lanes receive tail, tail+1, … in ascending lane order; disabled lanes are skipped. tail advances by n, mod 2^robIndexWidth, wrapping naturally.
  - Stalled request: nothing is allocated; `robEn_o` is all 0 next cycle. Upstream holds its inputs.
- Retire:
  - r = popcount(retireEn_i). Legal only if retireEn_i is contiguous from bit 0 and r ≤ (depth − free).
  - Legal: head += r, free += r.
  - Illegal: the whole request is ignored and `retireErr_o` pulses for 1 cycle.
- Simultaneous events: free_next = free − n_accepted + r_legal. Each unit load counter changes by (accepted lanes of that unit) − (legal retires of that unit). Both can occur in the same cycle.
- Idle:
  - If a unit's load is 0, its idle counter increments, saturating; otherwise it clears to 0.
  - `unitIdle_o[u]` = (counter == idleCycles).
  - Any allocation to the unit deasserts its idle flag on the next edge.
- Reset values:
  - All outputs 0, except `freeCount_o` = 2^robIndexWidth and `unitIdle_o` = all 1.
  - head = tail = 0.
  - Idle counters are preset to idleCycles.
  - Reset mid-operation discards all in-flight entries; the first post-reset allocation gets ID 0.

## Timing
- Latency from accept to `robEn_o`/`robId_o`/payload is 1 cycle. Outputs are registered and valid for exactly one cycle per accept.
- `freeCount_o` and `unitLoad_o` reflect allocations and retires of cycle t at t+1.
- `stall_o` is combinational from `enable_i` and the registered `free`. It has no dependency on `retireEn_i`.
- Throughput is up to `lanes` allocations and `lanes` retires per cycle, sustained.

## Test plan
All scenarios use lanes=4, robIndexWidth=3 (depth 8), idleCycles=4.
- Reset, then enable_i=1111 with units 0,1,0,2. Required: next cycle robId_o=0,1,2,3; freeCount_o=4; unitLoad_o[0]=2, [1]=1, [2]=1; unitIdle_o[0..2]=0.
- With free=4, enable_i=1010 then 1111. Required: first request gets IDs 4,5 in lanes 0 and 2. Second request stalls (4 > 2) and robEn_o=0000.
- Wrap-around: allocate IDs 0–7, retire 4 entries, then allocate 4. Required: new IDs are 0,1,2,3 and freeCount_o=0.
- Same cycle with free=0: retire 2 and request 1. Required: stall_o=1 that cycle, no allocation, freeCount_o becomes 2; the next cycle's request of 1 succeeds.
- Retire 1011, or retire 3 with only 2 in flight. Required: retireErr_o=1 for one cycle; head and free unchanged.
- Unit 0 load drops to 0. Required: unitIdle_o[0] rises exactly 4 cycles later. Asserting reset_i mid-stream then returns freeCount_o=8 and all unitIdle_o=1 on the next cycle.
